// File: rtl/frame_reader_if.sv
// frame_reader_if: bus-master read port plus pixel stream port.
// master = DMA side (frame_reader), slave = memory/sink side.
interface frame_reader_if;
  logic        requestBus;
  logic        busGrant;
  logic        beginTransactionOut;
  logic        readNotWriteOut;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic [31:0] pixelData;
  logic        pixelValid;
  logic        pixelReady;
  logic        pixelFirst;

  modport master (
    output requestBus, beginTransactionOut, readNotWriteOut,
    output addressDataOut, byteEnablesOut, burstSizeOut,
    output pixelData, pixelValid, pixelFirst,
    input  busGrant, addressDataIn, dataValidIn,
    input  endTransactionIn, busErrorIn, pixelReady
  );

  modport slave (
    input  requestBus, beginTransactionOut, readNotWriteOut,
    input  addressDataOut, byteEnablesOut, burstSizeOut,
    input  pixelData, pixelValid, pixelFirst,
    output busGrant, addressDataIn, dataValidIn,
    output endTransactionIn, busErrorIn, pixelReady
  );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: burst-read DMA streaming a frame buffer to a pixel port.
// Ports: clock/reset, CI port (ciStart..ciDone), bus = frame_reader_if.master.
// Option: FRAME_READER_BYTESWAP_EN swaps bytes within each 16-bit half.
module frame_reader #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int fifoDepthLog2 = 5,
  parameter int maxBurstWords = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  frame_reader_if.master bus
);
  localparam int AW = fifoDepthLog2;
  localparam int CW = fifoDepthLog2 + 1;
  localparam int DEPTH = 1 << fifoDepthLog2;

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_INIT, S_DATA
  } state_t;

  state_t state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [19:0] wpf_q, wpf_d;
  logic [31:0] addr_q, addr_d;
  logic [19:0] rem_q, rem_d;
  logic active_q, active_d;
  logic cont_q, cont_d;
  logic first_q, first_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic beg_q, beg_d;
  logic [31:0] aout_q, aout_d;
  logic [7:0] size_q, size_d;

  logic [32:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [8:0] blen;
  logic [CW-1:0] free;
  logic push, pop, busy, ci_sel;
  logic [2:0] cmd;
  logic [31:0] wdata;
  logic [32:0] head;
  logic [28:0] unused_a;

  assign unused_a = ciValueA[31:3];
  assign cmd = ciValueA[2:0];
  assign ci_sel = ciStart & ciCke & (ciN == customInstructionId);
  assign ciDone = ci_sel;

  assign blen = (rem_q >= 20'(maxBurstWords)) ?
                9'(maxBurstWords) : rem_q[8:0];
  assign free = CW'(DEPTH) - cnt_q;
  assign busy = (state_q != S_IDLE) | (active_q & (rem_q != 20'd0));

`ifdef FRAME_READER_BYTESWAP_EN
  assign wdata = {bus.addressDataIn[23:16], bus.addressDataIn[31:24],
                  bus.addressDataIn[7:0], bus.addressDataIn[15:8]};
`else
  assign wdata = bus.addressDataIn;
`endif

  // Data arriving together with an error is dropped.
  assign push = (state_q == S_DATA) & bus.dataValidIn & ~bus.busErrorIn;
  assign pop = (cnt_q != '0) & bus.pixelReady;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  assign head = mem[rd_q];
  assign bus.pixelValid = (cnt_q != '0);
  assign bus.pixelData = bus.pixelValid ? head[31:0] : 32'd0;
  assign bus.pixelFirst = bus.pixelValid & head[32];

  assign bus.requestBus = (state_q == S_REQ);
  assign bus.beginTransactionOut = beg_q;
  assign bus.readNotWriteOut = beg_q;
  assign bus.byteEnablesOut = {4{beg_q}};
  assign bus.addressDataOut = aout_q;
  assign bus.burstSizeOut = size_q;

  always_comb begin
    ciResult = 32'd0;
    if (ci_sel) begin
      unique case (cmd)
        3'd0: ciResult = base_q;
        3'd2: ciResult = {12'd0, wpf_q};
        3'd5: ciResult = {29'd0, err_q, done_q, busy};
        default: ciResult = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    base_d = base_q;
    wpf_d = wpf_q;
    addr_d = addr_q;
    rem_d = rem_q;
    active_d = active_q;
    cont_d = cont_q;
    first_d = first_q;
    done_d = done_q;
    err_d = err_q;
    beg_d = 1'b0;
    aout_d = 32'd0;
    size_d = 8'd0;

    unique case (state_q)
      S_IDLE: begin
        if (active_q && rem_q != 20'd0 && 32'(free) >= 32'(blen))
          state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.busGrant) begin
          state_d = S_INIT;
          beg_d = 1'b1;
          aout_d = addr_q;
          size_d = 8'(blen - 9'd1);
        end
      end
      S_INIT: state_d = S_DATA;
      S_DATA: begin
        if (bus.busErrorIn) begin
          state_d = S_IDLE;
          err_d = 1'b1;
          cont_d = 1'b0;
          active_d = 1'b0;
          rem_d = 20'd0;
        end else begin
          if (bus.dataValidIn) begin
            addr_d = addr_q + 32'd4;
            rem_d = rem_q - 20'd1;
            first_d = 1'b0;
            if (rem_q == 20'd1) begin
              done_d = 1'b1;
              // Continuous mode reloads the frame immediately.
              if (cont_q && wpf_q != 20'd0) begin
                addr_d = base_q;
                rem_d = wpf_q;
                first_d = 1'b1;
              end else begin
                active_d = 1'b0;
              end
            end
          end
          if (bus.endTransactionIn) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ci_sel) begin
      unique case (cmd)
        3'd1: base_d = {ciValueB[31:2], 2'b00};
        3'd3: wpf_d = ciValueB[19:0];
        3'd4: begin
          unique case (1'b1)
            ciValueB[1:0] == 2'b00: begin
              active_d = 1'b0;
              cont_d = 1'b0;
            end
            ciValueB[0] ^ ciValueB[1]: begin
              addr_d = base_q;
              rem_d = wpf_q;
              first_d = 1'b1;
              if (wpf_q == 20'd0) begin
                done_d = 1'b1;
                active_d = 1'b0;
                cont_d = 1'b0;
              end else begin
                active_d = 1'b1;
                cont_d = ciValueB[0];
              end
            end
            default: ;
          endcase
        end
        3'd6: begin
          done_d = 1'b0;
          err_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q <= '0;
      wpf_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      active_q <= 1'b0;
      cont_q <= 1'b0;
      first_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      beg_q <= 1'b0;
      aout_q <= '0;
      size_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      wpf_q <= wpf_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      active_q <= active_d;
      cont_q <= cont_d;
      first_q <= first_d;
      done_q <= done_d;
      err_q <= err_d;
      beg_q <= beg_d;
      aout_q <= aout_d;
      size_q <= size_d;
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_q] <= {first_q, wdata};
  end
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: scoreboard bench for frame_reader.
// Memory slave model, pixel and burst monitors, directed CI scenarios.
`timescale 1ns/1ps
module tb_frame_reader;
  logic clock = 1'b0;
  logic reset;
  logic ciStart, ciCke;
  logic [7:0] ciN;
  logic [31:0] ciValueA, ciValueB, ciResult;
  logic ciDone;

  frame_reader_if fr_if();

  frame_reader #(
    .customInstructionId(8'd0),
    .fifoDepthLog2(5),
    .maxBurstWords(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ciStart(ciStart),
    .ciCke(ciCke),
    .ciN(ciN),
    .ciValueA(ciValueA),
    .ciValueB(ciValueB),
    .ciResult(ciResult),
    .ciDone(ciDone),
    .bus(fr_if.master)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0] s;
  } burst_t;

  int pass_cnt = 0;
  int chk_cnt = 0;
  logic [32:0] pix_q[$];
  burst_t bq[$];
  bit cont_chk = 0;
  logic [31:0] cont_base = 0;
  int cont_frames = 0;
  int bursts_seen = 0;
  bit req_seen = 0;
  int bidx = 0;
  int err_at = -1;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] xdat(input logic [31:0] a);
    logic [31:0] d;
    d = mdat(a);
`ifdef FRAME_READER_BYTESWAP_EN
    return {d[23:16], d[31:24], d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ci(input logic [7:0] n, input logic [2:0] c,
                    input logic [31:0] b, output logic [31:0] r,
                    output logic d);
    @(posedge clock); #1;
    ciStart = 1; ciCke = 1; ciN = n;
    ciValueA = {29'd0, c}; ciValueB = b;
    #1; r = ciResult; d = ciDone;
    @(posedge clock); #1;
    ciStart = 0; ciCke = 0; ciN = 0; ciValueA = 0; ciValueB = 0;
  endtask

  task automatic ciw(input logic [2:0] c, input logic [31:0] b);
    logic [31:0] r;
    logic d;
    ci(8'd0, c, b, r, d);
  endtask

  task automatic cir(input logic [2:0] c, output logic [31:0] r);
    logic d;
    ci(8'd0, c, 32'd0, r, d);
  endtask

  task automatic push_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      pix_q.push_back({i == 0, xdat(base + 32'(4 * i))});
  endtask

  task automatic push_bursts(input logic [31:0] base, input int n);
    int rem, l;
    logic [31:0] a;
    rem = n; a = base;
    while (rem > 0) begin
      l = (rem > 16) ? 16 : rem;
      bq.push_back('{a: a, s: 8'(l - 1)});
      a = a + 32'(4 * l);
      rem = rem - l;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && (pix_q.size() != 0 || bq.size() != 0); i++)
      @(posedge clock);
    chk_cnt++;
    if (pix_q.size() == 0 && bq.size() == 0) pass_cnt++;
    else $display("FAIL %s drain timeout: words left %0d, bursts left %0d",
                  name, pix_q.size(), bq.size());
  endtask

  function automatic logic [63:0] outs();
    return {fr_if.requestBus, fr_if.beginTransactionOut,
            fr_if.readNotWriteOut, fr_if.byteEnablesOut,
            fr_if.burstSizeOut, fr_if.pixelValid, fr_if.pixelFirst,
            fr_if.addressDataOut[15:0] | fr_if.pixelData[15:0]
              | fr_if.addressDataOut[31:16] | fr_if.pixelData[31:16]};
  endfunction

  // Monitors: pixel scoreboard and burst scoreboard.
  always @(negedge clock) begin
    logic [32:0] e;
    burst_t b;
    if (!reset) begin
      if (fr_if.requestBus) req_seen = 1;
      if (fr_if.pixelValid && fr_if.pixelReady) begin
        if (pix_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL pixel: unexpected word %h first %b",
                   fr_if.pixelData, fr_if.pixelFirst);
        end else begin
          e = pix_q.pop_front();
          check("pixel", {31'd0, fr_if.pixelFirst, fr_if.pixelData},
                {31'd0, e});
        end
      end
      if (fr_if.beginTransactionOut) begin
        bursts_seen++;
        check("rnw_be", {fr_if.readNotWriteOut, fr_if.byteEnablesOut},
              5'h1F);
        if (cont_chk) begin
          check("cont_burst", {fr_if.addressDataOut, fr_if.burstSizeOut},
                {cont_base, 8'd3});
          push_frame(cont_base, 4);
          cont_frames++;
        end else if (bq.size() == 0) begin
          chk_cnt++;
          $display("FAIL burst: unexpected at %h size %0d",
                   fr_if.addressDataOut, fr_if.burstSizeOut);
        end else begin
          b = bq.pop_front();
          check("burst", {fr_if.addressDataOut, fr_if.burstSizeOut}, b);
        end
      end
    end
  end

  // Memory slave model.
  initial begin
    logic [31:0] a;
    int n;
    fr_if.busGrant = 0;
    fr_if.dataValidIn = 0;
    fr_if.endTransactionIn = 0;
    fr_if.busErrorIn = 0;
    fr_if.addressDataIn = 0;
    forever begin
      @(posedge clock); #1;
      fr_if.busGrant = fr_if.requestBus & ~reset;
      if (fr_if.beginTransactionOut && !reset) begin
        a = fr_if.addressDataOut;
        n = int'(fr_if.burstSizeOut) + 1;
        fr_if.busGrant = 0;
        bidx++;
        for (int i = 0; i < n; i++) begin
          @(posedge clock); #1;
          if (reset) begin
            fr_if.dataValidIn = 0;
            fr_if.endTransactionIn = 0;
            break;
          end
          if (bidx == err_at) begin
            fr_if.busErrorIn = 1;
            @(posedge clock); #1;
            fr_if.busErrorIn = 0;
            break;
          end
          fr_if.dataValidIn = 1;
          fr_if.addressDataIn = mdat(a + 32'(4 * i));
          fr_if.endTransactionIn = (i == n - 1);
        end
        if (fr_if.dataValidIn) begin
          @(posedge clock); #1;
        end
        fr_if.dataValidIn = 0;
        fr_if.endTransactionIn = 0;
        fr_if.addressDataIn = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic d;
    int b0, f0;
    bit seen;
    reset = 1;
    ciStart = 0; ciCke = 0; ciN = 0; ciValueA = 0; ciValueB = 0;
    fr_if.pixelReady = 1;
    cycles(3); #1;
    check("reset_outs", outs(), 64'd0);
    check("reset_ci", {31'd0, ciDone, ciResult}, 64'd0);
    @(posedge clock); #1;
    reset = 0;
    cir(3'd5, r);
    check("reset_status", r, 32'd0);

    // Single frame, 40 words.
    ciw(3'd1, 32'h0000_1003);
    ciw(3'd3, 32'd40);
    cir(3'd0, r);
    check("base_rd", r, 32'h1000);
    ci(8'd0, 3'd2, 32'd0, r, d);
    check("wpf_rd", {d, r}, {1'b1, 32'd40});
    ci(8'd5, 3'd0, 32'd0, r, d);
    check("ci_unsel", {d, r}, 33'd0);
    push_bursts(32'h1000, 40);
    push_frame(32'h1000, 40);
    ciw(3'd4, 32'd2);
    wait_drain("single");
    cycles(5);
    cir(3'd5, r);
    check("single_status", r, 32'b010);
    ciw(3'd6, 0);

    // Continuous mode, 4-word frames, then stop.
    ciw(3'd1, 32'h2000);
    ciw(3'd3, 32'd4);
    cont_base = 32'h2000;
    cont_chk = 1;
    f0 = cont_frames;
    ciw(3'd4, 32'd1);
    cycles(80);
    ciw(3'd4, 32'd0);
    cycles(40);
    cont_chk = 0;
    check("cont_frames", {63'd0, (cont_frames - f0) >= 2}, 64'd1);
    wait_drain("cont");
    req_seen = 0;
    cycles(50);
    check("cont_stopped", {63'd0, req_seen}, 64'd0);
    cir(3'd5, r);
    check("cont_status", r, 32'b010);
    ciw(3'd6, 0);

    // Backpressure: 64 words into a 32-entry FIFO.
    fr_if.pixelReady = 0;
    ciw(3'd1, 32'h4000);
    ciw(3'd3, 32'd64);
    push_bursts(32'h4000, 64);
    push_frame(32'h4000, 64);
    b0 = bursts_seen;
    ciw(3'd4, 32'd2);
    cycles(200); #1;
    check("bp_bursts", bursts_seen - b0, 2);
    check("bp_noreq", {63'd0, fr_if.requestBus}, 64'd0);
    check("bp_head", {31'd0, fr_if.pixelValid, fr_if.pixelData},
          {31'd0, 1'b1, xdat(32'h4000)});
    fr_if.pixelReady = 1;
    wait_drain("backpressure");
    cycles(5);
    cir(3'd5, r);
    check("bp_status", r, 32'b010);
    ciw(3'd6, 0);

    // Bus error on the second burst, continuous mode.
    ciw(3'd1, 32'h3000);
    ciw(3'd3, 32'd40);
    err_at = bidx + 2;
    bq.push_back('{a: 32'h3000, s: 8'd15});
    bq.push_back('{a: 32'h3040, s: 8'd15});
    push_frame(32'h3000, 16);
    ciw(3'd4, 32'd1);
    wait_drain("buserr");
    cycles(10);
    cir(3'd5, r);
    check("err_status", r, 32'b100);
    req_seen = 0;
    cycles(50);
    check("err_noreq", {63'd0, req_seen}, 64'd0);
    ciw(3'd6, 0);
    cir(3'd5, r);
    check("err_clear", r, 32'd0);
    err_at = -1;

    // Zero words per frame.
    ciw(3'd3, 32'd0);
    req_seen = 0;
    ciw(3'd4, 32'd2);
    cycles(20);
    check("zero_noreq", {63'd0, req_seen}, 64'd0);
    cir(3'd5, r);
    check("zero_status", r, 32'b010);
    ciw(3'd6, 0);

    // Reset in the middle of a data phase.
    ciw(3'd1, 32'h8000);
    ciw(3'd3, 32'd16);
    bq.push_back('{a: 32'h8000, s: 8'd15});
    push_frame(32'h8000, 16);
    ciw(3'd4, 32'd2);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock); #2;
      if (fr_if.dataValidIn) seen = 1;
    end
    check("rst_data_seen", {63'd0, seen}, 64'd1);
    cycles(2); #2;
    reset = 1;
    #1;
    check("rst_mid_outs", outs(), 64'd0);
    check("rst_mid_pix", {32'd0, fr_if.pixelData}, 64'd0);
    cycles(3); #1;
    pix_q.delete();
    bq.delete();
    reset = 0;
    cir(3'd0, r);
    check("rst_base", r, 32'd0);
    cir(3'd5, r);
    check("rst_status", r, 32'd0);
    cycles(20);
    check("rst_idle", {63'd0, fr_if.requestBus}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Bus-master DMA that reads a frame buffer from shared memory with burst reads.
- Streams the words out over a valid/ready pixel interface for the display/processing path.
- Configured and controlled through a custom-instruction (CI) port; runs in the system bus clock domain only.
- Internal FIFO decouples bus bursts from the stream consumer.

Parameters:
- customInstructionId, 8'd0, CI number this block responds to (ciN match).
- fifoDepthLog2, 5, log2 of FIFO depth in 33-bit entries (32 data bits + frame-start tag); minimum 4.
- maxBurstWords, 16, maximum words per bus burst; must be ≤ 2^fifoDepthLog2 and ≤ 256.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ciStart, ciCke  in  1 each  CI start and clock-enable
- ciN  in  8  CI number
- ciValueA, ciValueB  in  32 each  CI operands
- ciResult  out  32  CI result; 0 when not selected
- ciDone  out  1  CI done; combinational = ciStart & ciCke & (ciN == customInstructionId)
- requestBus  out  1  bus request
- busGrant  in  1  bus grant
- beginTransactionOut, readNotWriteOut  out  1 each  transaction start; read flag
- addressDataOut  out  32  burst start address
- byteEnablesOut  out  4  byte enables
- burstSizeOut  out  8  burst length minus 1
- addressDataIn  in  32  read data from slave
- dataValidIn, endTransactionIn, busErrorIn  in  1 each  slave data valid; slave end of transaction; bus error
- pixelData  out  32  stream data (two RGB565 pixels)
- pixelValid  out  1  stream valid
- pixelReady  in  1  stream ready
- pixelFirst  out  1  marks the first word of a frame; qualified by pixelValid

Behaviour:
- Reset: all outputs 0 and all registers 0; state machine returns to IDLE; FIFO emptied.
- Reset asserted mid-burst aborts the transaction immediately; the block does not drive endTransaction.
- CI commands, selected by ciValueA[2:0]:
  - 0: read base address.
  - 1: write base address = {ciValueB[31:2], 2'b00}.
  - 2: read words-per-frame.
  - 3: write words-per-frame = ciValueB[19:0].
  - 4: control. ciValueB[1:0] = 01 starts continuous mode; 10 takes a single frame; 00 stops; 11 is ignored.
  - 5: read status = {29'd0, busErr, frameDone, busy}.
  - 6: clear sticky frameDone and busErr.
  - 7: read 0.
- Frame start: base address and words-per-frame are latched into address/remaining counters.
  - A start with words-per-frame = 0 performs no bus activity and sets frameDone.
- States:
  - IDLE -> REQ when a frame is active, remaining > 0, and FIFO free entries ≥ burstLen.
  - burstLen = min(maxBurstWords, remaining).
  - REQ: requestBus = 1; go to INIT on busGrant.
  - INIT: one cycle with beginTransactionOut = 1, readNotWriteOut = 1, byteEnablesOut = 4'hF, addressDataOut = address, burstSizeOut = burstLen - 1. All of these are registered; they are 0 in every other cycle.
  - DATA: each dataValidIn cycle pushes addressDataIn into the FIFO, increments address by 4, and decrements remaining.
    - endTransactionIn goes to IDLE.
    - busErrorIn goes to IDLE, sets busErr, stops continuous mode, and discards the rest of the frame. Words already in the FIFO are kept.
- Frame done: remaining reaches 0 after the final push.
  - frameDone sets.
  - In continuous mode, a new frame restarts from the current base on the next cycle.
  - In single mode, the block stops.
- Stop while busy: the current burst completes, then no further requests are made; the FIFO still drains.
- busy = state != IDLE, or a frame is in progress with remaining > 0.
- FIFO:
  - The first word of each frame is tagged; the tag drives pixelFirst.
  - pixelData/pixelValid come from the registered FIFO head.
  - A transfer occurs when pixelValid & pixelReady.
  - A simultaneous push and pop is allowed at any fill level.
  - A push into a full FIFO cannot occur, because of the free-space check before REQ.
- Address arithmetic is 32-bit and wraps at 2^32 without error.

Optional Feature:
- Macro: FRAME_READER_BYTESWAP_EN.
- Defined: each 16-bit half of a read word has its bytes swapped before FIFO entry, i.e. {b2, b3, b0, b1} from {b3, b2, b1, b0}. This serves big-endian RGB565 displays.
- Undefined: data passes unchanged.

Test Plan:
- Base 0x1000, words 40, single frame, pixelReady = 1 -> bursts at 0x1000/16, 0x1040/16, 0x1080/8. 40 words out in order; pixelFirst only on word 0. frameDone = 1; busy = 0 afterwards.
- Continuous mode, words 4 -> repeated 4-word bursts at the base; pixelFirst every 4th word. A stop command lets the current frame finish; then requestBus stays 0.
- pixelReady = 0, fifoDepthLog2 = 5, words 64 -> exactly 32 words fetched, then no request. Releasing ready resumes fetching; all 64 words arrive, none lost.
- busErrorIn during the 2nd burst -> status reads 0b100 (busErr = 1, busy = 0). Continuous mode is cleared; CI 6 clears the status to 0.
- Words-per-frame 0 plus single start -> no requestBus; status frameDone = 1.
- Reset asserted mid-DATA -> all outputs 0 immediately; after release, CI reads base = 0 and status = 0.
